mem_access_unit: RTL and testbench

- Load/store sequencer directly upstream of the word-only data memory in the ARMv4 core.
- Accepts one LDR/STR/LDRB/STRB/LDRH/STRH/LDRSB/LDRSH request at a time from the memory pipeline stage.
- Drives the data memory's single word address, read-enable and write-enable, and formats returned words into byte, halfword or word results.
- Sub-word stores are done as read-modify-write, because the data memory has no byte enables.

---
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bus of the load/store sequencer.
interface mem_access_unit_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              ready;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  ready, rdata, done
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output ready, rdata, done
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-only data memory; sub-word stores use read-modify-write.
// Optional macro ROTATE_UNALIGNED_EN: unaligned word loads rotate right by 8*addr[1:0].
module mem_access_unit #(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.slave   bus,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_datain,
    output logic               mem_re,
    output logic               mem_we,
    input  logic [DATA_W-1:0]  mem_dataout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sign_ext_q, sign_ext_d;
    logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;

    logic [1:0]        size_norm;
    logic [DATA_W-1:0] load_word;

    function automatic logic [DATA_W-1:0] load_format(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        off,
        input logic [1:0]        sz,
        input logic              sext
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: begin
`ifdef ROTATE_UNALIGNED_EN
                case (off)
                    2'd1:    r = {word[7:0],  word[31:8]};
                    2'd2:    r = {word[15:0], word[31:16]};
                    2'd3:    r = {word[23:0], word[31:24]};
                    default: r = word;
                endcase
`else
                r = word;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] merge_store(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wd,
        input logic [1:0]        off,
        input logic [1:0]        sz
    );
        logic [DATA_W-1:0] r;
        r = old;
        case (sz)
            SZ_BYTE: r[{off, 3'b000} +: 8] = wd[7:0];
            SZ_HALF: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    assign size_norm = (bus.size == 2'b11) ? SZ_WORD : bus.size;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        size_d       = size_q;
        sign_ext_d   = sign_ext_q;
        rdata_hold_d = rdata_hold_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    addr_d     = bus.addr;
                    wdata_d    = bus.wdata;
                    we_d       = bus.we;
                    size_d     = size_norm;
                    sign_ext_d = bus.sign_ext;
                    // Only a full-word store can skip the read half of read-modify-write
                    if (bus.we && size_norm == SZ_WORD) state_d = S_WR;
                    else                                state_d = S_RD;
                end
            end
            S_RD:  state_d = we_q ? S_WR : S_FIN;
            S_WR:  state_d = S_FIN;
            default: begin
                state_d = S_IDLE;
                if (!we_q) rdata_hold_d = load_word;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            sign_ext_q   <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sign_ext_q   <= sign_ext_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign load_word = load_format(mem_dataout, addr_q[1:0], size_q, sign_ext_q);

    assign bus.ready = (state_q == S_IDLE);
    assign bus.done  = (state_q == S_FIN);
    assign mem_re    = (state_q == S_RD);
    assign mem_we    = (state_q == S_WR);
    assign mem_addr  = {addr_q[DATA_W-1:2], 2'b00};

    // mem_dataout is frozen during WR (no read issued), so the merge is stable for the negedge write
    assign mem_datain = (state_q == S_WR) ? merge_store(mem_dataout, wdata_q, addr_q[1:0], size_q)
                                          : '0;
    assign bus.rdata  = (state_q == S_FIN && !we_q) ? load_word : rdata_hold_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model behind it.
module tb_mem_access_unit;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_W(32)) bus_if ();

    logic [31:0] mem_addr, mem_datain, mem_dataout;
    logic        mem_re, mem_we;

    mem_access_unit #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_dataout (mem_dataout)
    );

    logic [31:0] mem [0:63];
    always @(posedge clk) if (mem_re) mem_dataout <= mem[mem_addr[7:2]];
    always @(negedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_datain;

`ifdef ROTATE_UNALIGNED_EN
    localparam logic [31:0] UNAL_EXP = 32'h44112233;
`else
    localparam logic [31:0] UNAL_EXP = 32'h11223344;
`endif

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_datain;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [22];
    int          n_tests;
    int          n_fail;
    logic [31:0] hold_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic [31:0] ed, input int lat);
        vec_t v;
        v.we = we; v.size = sz; v.sext = sx; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_datain = ed; v.exp_lat = lat;
        return v;
    endfunction

    task automatic drive_req(input logic we, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd);
        bus_if.we = we; bus_if.size = sz; bus_if.sign_ext = sx;
        bus_if.addr = a; bus_if.wdata = wd; bus_if.req = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          cyc;
        int          we_cnt;
        logic [31:0] datain_seen;
        logic        got_done, bad_excl, bad_ready, bad_addr;
        cyc = 0; we_cnt = 0; datain_seen = '0;
        got_done = 0; bad_excl = 0; bad_ready = 0; bad_addr = 0;
        @(negedge clk);
        check($sformatf("v%0d_ready_before", idx), bus_if.ready, 1);
        drive_req(v.we, v.size, v.sext, v.addr, v.wdata);
        while (!got_done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            bus_if.req = 1'b0;
            if (mem_re && mem_we) bad_excl = 1;
            if (bus_if.ready) bad_ready = 1;
            if (mem_addr !== {v.addr[31:2], 2'b00}) bad_addr = 1;
            if (mem_we) begin we_cnt++; datain_seen = mem_datain; end
            if (bus_if.done) begin
                got_done = 1;
                check($sformatf("v%0d_rdata_done", idx), bus_if.rdata, v.we ? hold_exp : v.exp_rdata);
            end
        end
        check($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
        check($sformatf("v%0d_we_cycles", idx), we_cnt, v.we ? 1 : 0);
        if (v.we) check($sformatf("v%0d_mem_datain", idx), datain_seen, v.exp_datain);
        check($sformatf("v%0d_re_we_exclusive", idx), bad_excl, 0);
        check($sformatf("v%0d_ready_busy", idx), bad_ready, 0);
        check($sformatf("v%0d_mem_addr", idx), bad_addr, 0);
        if (!v.we) hold_exp = v.exp_rdata;
        @(negedge clk);
        check($sformatf("v%0d_done_after", idx), bus_if.done, 0);
        check($sformatf("v%0d_rdata_hold", idx), bus_if.rdata, hold_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] done_m, ready_m, re_m;
        logic       bad;
        n_tests = 0; n_fail = 0; hold_exp = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem_dataout = '0;
        bus_if.req = 0; bus_if.we = 0; bus_if.size = 0; bus_if.sign_ext = 0;
        bus_if.addr = '0; bus_if.wdata = '0;
        rst_n = 1'b0;

        vecs[0]  = mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2);
        vecs[1]  = mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0,        2);
        vecs[2]  = mk(1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0,        32'h11223344, 2);
        vecs[3]  = mk(1, 2'b00, 0, 32'h21, 32'hFFFFFFAA, 32'h0,        32'h1122AA44, 3);
        vecs[4]  = mk(0, 2'b10, 0, 32'h20, 32'h0,        32'h1122AA44, 32'h0,        2);
        vecs[5]  = mk(1, 2'b10, 0, 32'h30, 32'h80017FFF, 32'h0,        32'h80017FFF, 2);
        vecs[6]  = mk(0, 2'b01, 1, 32'h32, 32'h0,        32'hFFFF8001, 32'h0,        2);
        vecs[7]  = mk(0, 2'b01, 0, 32'h32, 32'h0,        32'h00008001, 32'h0,        2);
        vecs[8]  = mk(0, 2'b00, 1, 32'h30, 32'h0,        32'hFFFFFFFF, 32'h0,        2);
        vecs[9]  = mk(0, 2'b00, 0, 32'h30, 32'h0,        32'h000000FF, 32'h0,        2);
        vecs[10] = mk(1, 2'b01, 0, 32'h33, 32'h1234BEEF, 32'h0,        32'hBEEF7FFF, 3);
        vecs[11] = mk(0, 2'b10, 0, 32'h30, 32'h0,        32'hBEEF7FFF, 32'h0,        2);
        vecs[12] = mk(1, 2'b10, 0, 32'h40, 32'h11223344, 32'h0,        32'h11223344, 2);
        vecs[13] = mk(0, 2'b10, 0, 32'h41, 32'h0,        UNAL_EXP,     32'h0,        2);
        vecs[14] = mk(0, 2'b00, 1, 32'h41, 32'h0,        32'h00000033, 32'h0,        2);
        vecs[15] = mk(0, 2'b11, 0, 32'h40, 32'h0,        32'h11223344, 32'h0,        2);
        vecs[16] = mk(1, 2'b11, 0, 32'h44, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 2);
        vecs[17] = mk(0, 2'b10, 0, 32'h44, 32'h0,        32'hCAFEF00D, 32'h0,        2);
        vecs[18] = mk(1, 2'b10, 0, 32'h4A, 32'h55667788, 32'h0,        32'h55667788, 2);
        vecs[19] = mk(0, 2'b10, 0, 32'h48, 32'h0,        32'h55667788, 32'h0,        2);
        vecs[20] = mk(0, 2'b01, 1, 32'h31, 32'h0,        32'h00007FFF, 32'h0,        2);
        vecs[21] = mk(0, 2'b00, 1, 32'h33, 32'h0,        32'hFFFFFFBE, 32'h0,        2);

        // Reset state, held across one posedge
        #12;
        check("rst_ready", bus_if.ready, 1);
        check("rst_done", bus_if.done, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_datain", mem_datain, 0);
        check("rst_rdata", bus_if.rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) run_vec(i, vecs[i]);

        // Async reset during the read cycle of a load
        @(negedge clk);
        drive_req(0, 2'b10, 0, 32'h10, 32'h0);
        @(negedge clk);
        bus_if.req = 1'b0;
        check("arst_load_in_rd", mem_re, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_re", mem_re, 0);
        check("arst_ready", bus_if.ready, 1);
        check("arst_done", bus_if.done, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_rdata", bus_if.rdata, 0);
        check("arst_mem_datain", mem_datain, 0);
        hold_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus_if.done || !bus_if.ready) bad = 1;
        end
        check("arst_no_done_after", bad, 0);

        // Reset in RD of a byte store must leave memory untouched
        @(negedge clk);
        drive_req(1, 2'b00, 0, 32'h11, 32'h00000077);
        @(negedge clk);
        bus_if.req = 1'b0;
        check("abort_in_rd", {mem_re, mem_we}, 2'b10);
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(100, mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 2));

        // Back-to-back loads with req held high
        @(negedge clk);
        drive_req(0, 2'b10, 0, 32'h20, 32'h0);
        done_m = '0; ready_m = '0; re_m = '0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            done_m[c]  = bus_if.done;
            ready_m[c] = bus_if.ready;
            re_m[c]    = mem_re;
            if (bus_if.done) check($sformatf("b2b_rdata_c%0d", c), bus_if.rdata, 32'h1122AA44);
            if (c == 7) bus_if.req = 1'b0;
        end
        check("b2b_done_pattern", done_m, 10'h124);
        check("b2b_ready_pattern", ready_m, 10'h248);
        check("b2b_re_pattern", re_m, 10'h092);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
